logic_exec_stage: RTL



---
 rtl/logic_exec_stage_if.sv | 30 +++
 rtl/logic_exec_stage.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/logic_exec_stage_if.sv
// logic_exec_stage_if
//   Handshake bundle between the logic slice, the exec stage and writeback.
//   Upstream side:   in_valid, in_ready, op, a, b
//   Downstream side: out_valid, out_ready, result, zero, all_ones
//   master - the environment (drives operations, accepts results)
//   slave  - the exec stage itself
interface logic_exec_stage_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             all_ones;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zero, all_ones
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zero, all_ones
  );
endinterface

// File: rtl/logic_exec_stage.sv
// logic_exec_stage
//   Registered bitwise-logic stage: NOT / AND / OR / XOR built from gate
//   primitives, results held in a 2-entry FIFO with valid/ready handshake.
//   Ports:
//     clk      - rising-edge clock
//     rst_n    - asynchronous active-low reset
//     bus      - logic_exec_stage_if.slave (operation in, result out)
//     op_count - results popped since reset, wraps silently
//
//   state | meaning
//   EMPTY | no entries; out_valid=0, in_ready=1
//   ONE   | one entry;  out_valid=1, in_ready=1
//   FULL  | two entries; out_valid=1, in_ready=0
//   The state encoding doubles as the 2-bit entry count.
module logic_exec_stage #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  logic_exec_stage_if.slave     bus,
  output logic [CNT_W-1:0]      op_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic             wr_ptr;
  logic             rd_ptr;
  logic [WIDTH-1:0] data_q [2];
  logic             zero_q [2];
  logic             ones_q [2];
  logic             out_valid_q;
  logic             in_ready_q;

  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] not_a;
  logic [WIDTH-1:0] and_ab;
  logic [WIDTH-1:0] or_ab;
  logic [WIDTH-1:0] xor_ab;
  logic [WIDTH-1:0] result_c;
  logic             push;
  logic             pop;

  assign a_in = bus.a;
  assign b_in = bus.b;

  // One cell of each kind per bit; no carries between bits.
  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    not u_not (not_a[i],  a_in[i]);
    and u_and (and_ab[i], a_in[i], b_in[i]);
    or  u_or  (or_ab[i],  a_in[i], b_in[i]);
    xor u_xor (xor_ab[i], a_in[i], b_in[i]);
  end

  always_comb begin
    result_c = '0;
    case (bus.op)
      2'b00:   result_c = not_a;
      2'b01:   result_c = and_ab;
      2'b10:   result_c = or_ab;
      2'b11:   result_c = xor_ab;
      default: result_c = '0;
    endcase
  end

  // Handshake qualifiers use only registered ready/valid, so in_ready never
  // depends combinationally on out_ready.
  assign push = bus.in_valid && in_ready_q;
  assign pop  = out_valid_q && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      data_q[0]   <= '0;
      data_q[1]   <= '0;
      zero_q[0]   <= 1'b1;
      zero_q[1]   <= 1'b1;
      ones_q[0]   <= 1'b0;
      ones_q[1]   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      op_count    <= '0;
    end else begin
      // Storage is only written on an accepted push, so X on op/a/b while
      // in_valid=0 never reaches the buffer.
      if (push) begin
        data_q[wr_ptr] <= result_c;
        zero_q[wr_ptr] <= (result_c == '0);
        ones_q[wr_ptr] <= &result_c;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr   <= ~rd_ptr;
        op_count <= op_count + CNT_ONE;
      end

      case (state)
        EMPTY: begin
          if (push) begin
            state       <= ONE;
            out_valid_q <= 1'b1;
            in_ready_q  <= 1'b1;
          end
        end
        ONE: begin
          if (push && !pop) begin
            state       <= FULL;
            out_valid_q <= 1'b1;
            in_ready_q  <= 1'b0;
          end else if (pop && !push) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        FULL: begin
          if (pop) begin
            state       <= ONE;
            out_valid_q <= 1'b1;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.result    = data_q[rd_ptr];
  assign bus.zero      = zero_q[rd_ptr];
  assign bus.all_ones  = ones_q[rd_ptr];

endmodule
